// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the 8-bit 4-stage accumulator-style processor:
// opcodes, condition-code bit positions, vector addresses and the pipeline
// latch structures used between ID/EX and EX/WB.
// ---------------------------------------------------------------------------
package proc_pkg;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 8;
   localparam int NUM_REGS = 4;

   // Opcodes (instruction bits [7:4]); 9..15 execute as NOP
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_MOV = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_OUT = 4'd6;
   localparam logic [3:0] OP_IN  = 4'd7;
   localparam logic [3:0] OP_HLT = 4'd8;

   // Condition-code register bit positions
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   // Memory location holding the start address / reserved interrupt vector
   localparam logic [ADDR_W-1:0] RESET_VEC = 8'h00;
   localparam logic [ADDR_W-1:0] INT_VEC   = 8'h01;

   // ID/EX latch: decoded fields plus operands read from the register file
   typedef struct packed {
      logic [3:0]        op;
      logic [1:0]        ra;
      logic [1:0]        rb;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } idex_t;

   // EX/WB latch: pending register write
   typedef struct packed {
      logic              we;
      logic [1:0]        wa;
      logic [DATA_W-1:0] wd;
   } exwb_t;

   // Signed overflow of a + b (or a - b when the caller passes sub = 1)
   function automatic logic ovf(input logic [DATA_W-1:0] a,
                                input logic [DATA_W-1:0] b,
                                input logic [DATA_W-1:0] r,
                                input logic              sub);
      logic b_sign;
      b_sign = sub ? ~b[DATA_W-1] : b[DATA_W-1];
      return (a[DATA_W-1] == b_sign) && (r[DATA_W-1] != a[DATA_W-1]);
   endfunction

endpackage

// File: rtl/processor_top_memory.sv
// ---------------------------------------------------------------------------
// memory
// Unified 256x8 instruction/data memory. One combinational read port used
// by fetch. The write port exists so the array has a real driver; the core
// ties it off since no instruction stores to memory. Contents are never
// reset so preloaded programs survive reset.
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (asynchronous)
// ---------------------------------------------------------------------------
module memory
   import proc_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] Mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) Mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = Mem[i_raddr];

endmodule

// File: rtl/processor_top_reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Four 8-bit general registers, two asynchronous read ports and one write
// port. Reads of the register being written this cycle return the new data
// so ID sees a WB result without waiting a cycle. Not reset.
//   i_clk      : clock
//   i_ra_addr  : read port A address
//   i_rb_addr  : read port B address
//   o_ra_data  : read port A data
//   o_rb_data  : read port B data
//   i_we       : write enable
//   i_waddr    : write address
//   i_wdata    : write data
// ---------------------------------------------------------------------------
module reg_file
   import proc_pkg::*;
(
   input  logic              i_clk,
   input  logic [1:0]        i_ra_addr,
   input  logic [1:0]        i_rb_addr,
   output logic [DATA_W-1:0] o_ra_data,
   output logic [DATA_W-1:0] o_rb_data,
   input  logic              i_we,
   input  logic [1:0]        i_waddr,
   input  logic [DATA_W-1:0] i_wdata
);

   logic [DATA_W-1:0] file [0:NUM_REGS-1];

   always_ff @(posedge i_clk) begin
      if (i_we) file[i_waddr] <= i_wdata;
   end

   assign o_ra_data = (i_we && (i_waddr == i_ra_addr)) ? i_wdata : file[i_ra_addr];
   assign o_rb_data = (i_we && (i_waddr == i_rb_addr)) ? i_wdata : file[i_rb_addr];

endmodule

// File: rtl/processor_top.sv
// ---------------------------------------------------------------------------
// processor_top
// 8-bit, 4-stage (IF, ID, EX, WB) accumulator-style processor.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   In_port  : external input data, read by IN
//   i_int    : interrupt request, reserved and ignored
//   Out_port : registered output port, written by OUT
//   HLT      : set once a HLT instruction reaches EX, cleared only by reset
// Instruction byte: opcode [7:4], ra [3:2], rb [1:0].
// Operands are read in ID; EX forwards from the EX/WB latch and the register
// file forwards the WB write, so dependent instructions never stall.
// ---------------------------------------------------------------------------
module processor_top
   import proc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] In_port,
   input  logic              i_int,
   output logic [DATA_W-1:0] Out_port,
   output logic              HLT
);

   // ---------------- state ----------------
   logic [ADDR_W-1:0] PC;
   logic [3:0]        CCR_out;
   logic              r_started;   // low until the reset vector has been loaded
   logic [DATA_W-1:0] r_ifid_ir;
   idex_t             r_idex;
   exwb_t             r_exwb;

   // ---------------- wires ----------------
   logic [ADDR_W-1:0] w_fetch_addr;
   logic [DATA_W-1:0] w_fetch_data;
   logic [1:0]        w_id_ra;
   logic [1:0]        w_id_rb;
   logic [DATA_W-1:0] w_rf_a;
   logic [DATA_W-1:0] w_rf_b;
   logic [DATA_W-1:0] w_ex_a;
   logic [DATA_W-1:0] w_ex_b;
   logic [DATA_W:0]   w_sum9;
   logic [DATA_W-1:0] w_res;
   logic [3:0]        w_ccr_nxt;
   exwb_t             w_ex_wb;
   logic              w_halting;
   logic              w_unused;

   assign w_unused = i_int;

   // ---------------- IF ----------------
   // Before start-up PC is 0, so the same port fetches the reset vector.
   assign w_fetch_addr = r_started ? PC : RESET_VEC;

   memory u_Memory (
      .i_clk   (clk),
      .i_we    (1'b0),
      .i_waddr ('0),
      .i_wdata ('0),
      .i_raddr (w_fetch_addr),
      .o_rdata (w_fetch_data)
   );

   assign w_halting = (r_idex.op == OP_HLT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         PC        <= '0;
         r_started <= 1'b0;
         r_ifid_ir <= '0;
      end else begin
         if (!r_started) begin
            PC        <= w_fetch_data;
            r_started <= 1'b1;
            r_ifid_ir <= '0;
         end else if (HLT || w_halting) begin
            // PC frozen, bubbles injected behind the halt
            r_ifid_ir <= '0;
         end else begin
            PC        <= PC + 8'd1;
            r_ifid_ir <= w_fetch_data;
         end
      end
   end

   // ---------------- ID ----------------
   assign w_id_ra = r_ifid_ir[3:2];
   assign w_id_rb = r_ifid_ir[1:0];

   reg_file regFile (
      .i_clk     (clk),
      .i_ra_addr (w_id_ra),
      .i_rb_addr (w_id_rb),
      .o_ra_data (w_rf_a),
      .o_rb_data (w_rf_b),
      .i_we      (r_exwb.we),
      .i_waddr   (r_exwb.wa),
      .i_wdata   (r_exwb.wd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idex <= '0;
      end else begin
         r_idex.op <= r_ifid_ir[7:4];
         r_idex.ra <= w_id_ra;
         r_idex.rb <= w_id_rb;
         r_idex.a  <= w_rf_a;
         r_idex.b  <= w_rf_b;
      end
   end

   // ---------------- EX ----------------
   // The instruction one ahead sits in EX/WB and has not reached the file yet
   assign w_ex_a = (r_exwb.we && (r_exwb.wa == r_idex.ra)) ? r_exwb.wd : r_idex.a;
   assign w_ex_b = (r_exwb.we && (r_exwb.wa == r_idex.rb)) ? r_exwb.wd : r_idex.b;

   always_comb begin
      w_ex_wb   = '0;
      w_ccr_nxt = CCR_out;
      w_sum9    = '0;
      w_res     = '0;
      case (r_idex.op)
         OP_MOV: begin
            w_ex_wb.we = 1'b1;
            w_ex_wb.wa = r_idex.ra;
            w_ex_wb.wd = w_ex_b;
         end
         OP_ADD: begin
            w_sum9            = {1'b0, w_ex_a} + {1'b0, w_ex_b};
            w_res             = w_sum9[DATA_W-1:0];
            w_ccr_nxt[FLAG_C] = w_sum9[DATA_W];
            w_ccr_nxt[FLAG_V] = ovf(w_ex_a, w_ex_b, w_res, 1'b0);
         end
         OP_SUB: begin
            // Bit 8 of the 9-bit difference is the borrow (a < b unsigned)
            w_sum9            = {1'b0, w_ex_a} - {1'b0, w_ex_b};
            w_res             = w_sum9[DATA_W-1:0];
            w_ccr_nxt[FLAG_C] = w_sum9[DATA_W];
            w_ccr_nxt[FLAG_V] = ovf(w_ex_a, w_ex_b, w_res, 1'b1);
         end
         OP_AND: w_res = w_ex_a & w_ex_b;
         OP_OR:  w_res = w_ex_a | w_ex_b;
         OP_IN: begin
            w_ex_wb.we = 1'b1;
            w_ex_wb.wa = r_idex.rb;
            w_ex_wb.wd = In_port;
         end
         default: ;
      endcase

      // Arithmetic and logic ops share result write and Z/N update
      if ((r_idex.op == OP_ADD) || (r_idex.op == OP_SUB) ||
          (r_idex.op == OP_AND) || (r_idex.op == OP_OR)) begin
         w_ex_wb.we        = 1'b1;
         w_ex_wb.wa        = r_idex.ra;
         w_ex_wb.wd        = w_res;
         w_ccr_nxt[FLAG_Z] = (w_res == '0);
         w_ccr_nxt[FLAG_N] = w_res[DATA_W-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exwb   <= '0;
         CCR_out  <= '0;
         Out_port <= '0;
         HLT      <= 1'b0;
      end else begin
         r_exwb  <= w_ex_wb;
         CCR_out <= w_ccr_nxt;
         if (r_idex.op == OP_OUT) Out_port <= w_ex_b;
         if (w_halting)           HLT      <= 1'b1;
      end
   end

   // ---------------- WB ----------------
   // r_exwb drives the register-file write port directly.

endmodule

// File: tb/tb_processor_top.sv
// Directed bench for processor_top: preloads registers and memory through
// the hierarchy while reset is held, then checks state edge by edge.
// Edge k after reset release is E(k-1); samples are taken 1 ns after it.
module tb_processor_top;

   logic       clk;
   logic       rst;
   logic [7:0] in_port;
   logic       int_req;
   logic [7:0] out_port;
   logic       hlt;

   int n_checks = 0;
   int n_fail   = 0;

   processor_top dut (
      .clk      (clk),
      .rst      (rst),
      .In_port  (in_port),
      .i_int    (int_req),
      .Out_port (out_port),
      .HLT      (hlt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Assert reset and clear memory; caller loads program and registers next
   task automatic enter_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 256; i++) dut.u_Memory.Mem[i] = 8'h00;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst     = 1'b0;
      in_port = 8'h00;
      int_req = 1'b0;

      // ---------- scenarios 1-4 ----------
      enter_reset();
      chk("rst_pc",  {24'h0, dut.PC}, 32'h00);
      chk("rst_ccr", {28'h0, dut.CCR_out}, 32'h0);
      chk("rst_out", {24'h0, out_port}, 32'h00);
      chk("rst_hlt", {31'h0, hlt}, 32'h0);
      dut.regFile.file[0] = 8'hFF;
      dut.regFile.file[1] = 8'h02;
      dut.regFile.file[2] = 8'h05;
      dut.u_Memory.Mem[0] = 8'h02;
      dut.u_Memory.Mem[2] = 8'h21;   // ADD R0,R1
      dut.u_Memory.Mem[3] = 8'h19;   // MOV R2,R1
      dut.u_Memory.Mem[4] = 8'h31;   // SUB R0,R1
      dut.u_Memory.Mem[5] = 8'h49;   // AND R2,R1
      release_reset();
      tick(); chk("e0_pc", {24'h0, dut.PC}, 32'h02);
      tick(); chk("e1_pc", {24'h0, dut.PC}, 32'h03);
      tick(); chk("e2_ccr", {28'h0, dut.CCR_out}, 32'h0);
      tick(); // E3: ADD FF+02 -> 01, C=1
      chk("add_ccr", {28'h0, dut.CCR_out}, 32'h4);
      chk("add_c",   {31'h0, dut.CCR_out[2]}, 32'h1);
      chk("add_z",   {31'h0, dut.CCR_out[0]}, 32'h0);
      tick(); // E4
      chk("add_r0",  {24'h0, dut.regFile.file[0]}, 32'h01);
      chk("mov_ccr", {28'h0, dut.CCR_out}, 32'h4);
      tick(); // E5: SUB 01-02 -> FF, N=1 C=1
      chk("mov_r2",  {24'h0, dut.regFile.file[2]}, 32'h02);
      chk("sub_n",   {31'h0, dut.CCR_out[1]}, 32'h1);
      chk("sub_ccr", {28'h0, dut.CCR_out}, 32'h6);
      tick(); // E6: AND keeps C,V
      chk("sub_r0",  {24'h0, dut.regFile.file[0]}, 32'hFF);
      chk("and_ccr", {28'h0, dut.CCR_out}, 32'h4);
      tick(); // E7
      chk("and_r2",  {24'h0, dut.regFile.file[2]}, 32'h02);

      // ---------- scenario 5: EX forwarding ----------
      enter_reset();
      chk("rst2_pc",  {24'h0, dut.PC}, 32'h00);
      chk("rst2_ccr", {28'h0, dut.CCR_out}, 32'h0);
      dut.regFile.file[0] = 8'h03;
      dut.regFile.file[1] = 8'h04;
      dut.u_Memory.Mem[0] = 8'h02;
      dut.u_Memory.Mem[2] = 8'h21;   // ADD R0,R1
      dut.u_Memory.Mem[3] = 8'h60;   // OUT R0
      release_reset();
      tick(); tick(); tick();
      tick(); // E3
      chk("fw_ccr",     {28'h0, dut.CCR_out}, 32'h0);
      chk("fw_out_pre", {24'h0, out_port}, 32'h00);
      tick(); // E4
      chk("fw_out", {24'h0, out_port}, 32'h07);
      chk("fw_r0",  {24'h0, dut.regFile.file[0]}, 32'h07);
      enter_reset();
      chk("rst_clr_out", {24'h0, out_port}, 32'h00);

      // ---------- scenario 6: IN / HLT ----------
      dut.regFile.file[0] = 8'h3C;
      dut.regFile.file[1] = 8'h00;
      dut.regFile.file[3] = 8'h00;
      dut.u_Memory.Mem[0] = 8'h02;
      dut.u_Memory.Mem[2] = 8'h73;   // IN R3
      dut.u_Memory.Mem[3] = 8'h80;   // HLT
      dut.u_Memory.Mem[4] = 8'h21;   // ADD R0,R1
      in_port = 8'h5A;
      release_reset();
      tick(); tick(); tick();
      tick(); // E3
      chk("hlt_pre", {31'h0, hlt}, 32'h0);
      tick(); // E4
      chk("in_r3",   {24'h0, dut.regFile.file[3]}, 32'h5A);
      chk("hlt_set", {31'h0, hlt}, 32'h1);
      chk("hlt_pc",  {24'h0, dut.PC}, 32'h05);
      tick(); tick(); tick();
      tick(); // E8
      chk("hlt_pc_frozen", {24'h0, dut.PC}, 32'h05);
      chk("hlt_held",      {31'h0, hlt}, 32'h1);
      chk("hlt_r0",        {24'h0, dut.regFile.file[0]}, 32'h3C);
      enter_reset();
      chk("rst_clr_hlt", {31'h0, hlt}, 32'h0);
      chk("rst_clr_pc",  {24'h0, dut.PC}, 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
